// File: rtl/mips_mc_pkg.sv
// Shared definitions for the MIPS multicycle control FSM.
//   - 4-bit state encodings and the state_t type
//   - opcode / func constants recognised by the decoder
//   - datapath select encodings (RegDst, MemToReg, ALUSrcB, ALUOp, PCSrc)
//   - ctrl_t: the full control word driven into the datapath
//   - decode_next(): DECODE-state dispatch from opcode/func

package mips_mc_pkg;

    localparam int unsigned StateW = 4;

    typedef logic [StateW-1:0] state_t;

    localparam state_t S_FETCH  = 4'd0;
    localparam state_t S_DECODE = 4'd1;
    localparam state_t S_MEMADR = 4'd2;
    localparam state_t S_MEMRD  = 4'd3;
    localparam state_t S_MEMWB  = 4'd4;
    localparam state_t S_MEMWR  = 4'd5;
    localparam state_t S_REXEC  = 4'd6;
    localparam state_t S_RWB    = 4'd7;
    localparam state_t S_IEXEC  = 4'd8;
    localparam state_t S_IWB    = 4'd9;
    localparam state_t S_BEQ    = 4'd10;
    localparam state_t S_JUMP   = 4'd11;
    localparam state_t S_JAL    = 4'd12;
    localparam state_t S_JR     = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    localparam logic [1:0] MEMTOREG_ALU = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR = 2'b01;
    localparam logic [1:0] MEMTOREG_PC  = 2'b10;

    localparam logic [1:0] ALUSRCB_B       = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_SLT  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Returns S_FETCH for any unsupported opcode/func; the caller flags that as illegal.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_LW, OP_SW:      nxt = S_MEMADR;
            OP_RTYPE:          nxt = (fn == FN_JR) ? S_JR : S_REXEC;
            OP_BEQ:            nxt = S_BEQ;
            OP_J:              nxt = S_JUMP;
            OP_JAL:            nxt = S_JAL;
            OP_ADDI, OP_SLTI:  nxt = S_IEXEC;
            default:           nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// Pure combinational state-to-control-word decoder for the multicycle controller.
// Ports:
//   state_i      current FSM state
//   slti_i       IEXEC is executing slti (selects ALUOp slt instead of add)
//   mem_ready_i  memory handshake, qualifies the FETCH-cycle IR/PC loads
//   ctrl_o       full datapath control word (unlisted fields are 0)

module mips_mc_ctrl_decode
    import mips_mc_pkg::*;
(
    input  state_t state_i,
    input  logic   slti_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_IDLE;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_FOUR;
                // IR and PC only load once the instruction word is actually back.
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctrl_o.alu_src_b = ALUSRCB_IMM_SH2;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = MEMTOREG_MDR;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_REXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            S_RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RD;
                ctrl_o.mem_to_reg = MEMTOREG_ALU;
            end
            S_IEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = ALUSRCB_IMM;
                ctrl_o.alu_op    = slti_i ? ALUOP_SLT : ALUOP_ADD;
            end
            S_IWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RT;
                ctrl_o.mem_to_reg = MEMTOREG_ALU;
            end
            S_BEQ: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = ALUSRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_JUMP;
            end
            S_JAL: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_src     = PCSRC_JUMP;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = REGDST_RA;
                ctrl_o.mem_to_reg = MEMTOREG_PC;
            end
            S_JR: begin
                ctrl_o.pc_write = 1'b1;
                ctrl_o.pc_src   = PCSRC_REG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore multicycle control FSM for the MIPS multicycle datapath.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-low reset
//   opcode, func    IR[31:26] / IR[5:0], sampled only in DECODE
//   mem_ready       memory access completes this cycle (FETCH, MEMRD, MEMWR only)
//   pc_write .. pc_src   datapath enables and mux selects
//   illegal         one-cycle pulse in the FETCH after an unsupported instruction
//   state_dbg       current state encoding

module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int unsigned OPW    = 6,
    parameter int unsigned ALUOPW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OPW-1:0]    opcode,
    input  logic [OPW-1:0]    func,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              pc_write_cond,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic [1:0]        reg_dst,
    output logic [1:0]        mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [ALUOPW-1:0] alu_op,
    output logic [1:0]        pc_src,
    output logic              illegal,
    output logic [3:0]        state_dbg
);

    state_t state_q, state_d;
    logic   slti_q, slti_d;
    logic   sw_q, sw_d;
    logic   illegal_q, illegal_d;
    state_t dispatch;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    assign dispatch = decode_next(opcode, func);

    always_comb begin
        state_d   = S_FETCH;
        slti_d    = slti_q;
        sw_d      = sw_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                state_d   = dispatch;
                // Only these two bits of the opcode matter after DECODE.
                slti_d    = (opcode == OP_SLTI);
                sw_d      = (opcode == OP_SW);
                illegal_d = (dispatch == S_FETCH);
            end
            S_MEMADR: state_d = sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_BEQ, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            slti_q    <= 1'b0;
            sw_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            slti_q    <= slti_d;
            sw_q      <= sw_d;
            illegal_q <= illegal_d;
        end
    end

    mips_mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .slti_i      (slti_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Holding rst low forces every enable and select to zero, so an aborted
    // instruction cannot complete a write in the reset cycle.
    always_comb begin
        ctrl_gated = rst ? ctrl : CTRL_IDLE;
    end

    assign pc_write      = ctrl_gated.pc_write;
    assign pc_write_cond = ctrl_gated.pc_write_cond;
    assign iord          = ctrl_gated.iord;
    assign mem_read      = ctrl_gated.mem_read;
    assign mem_write     = ctrl_gated.mem_write;
    assign ir_write      = ctrl_gated.ir_write;
    assign reg_write     = ctrl_gated.reg_write;
    assign reg_dst       = ctrl_gated.reg_dst;
    assign mem_to_reg    = ctrl_gated.mem_to_reg;
    assign alu_src_a     = ctrl_gated.alu_src_a;
    assign alu_src_b     = ctrl_gated.alu_src_b;
    assign alu_op        = ctrl_gated.alu_op;
    assign pc_src        = ctrl_gated.pc_src;
    assign illegal       = rst & illegal_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed scenarios plus a
// randomized instruction stream checked against a phase-sequence model.

module tb_mips_mc_controller;
    import mips_mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
    logic       alu_src_a, illegal;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mips_mc_controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .func          (func),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .illegal       (illegal),
        .state_dbg     (state_dbg)
    );

    // Expected visible behaviour for one cycle.
    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] rd, m2r;
        logic       asa;
        logic [1:0] asb, aop, psrc;
        logic       ill;
    } exp_t;

    typedef struct packed {
        exp_t e;
        logic mr;   // mem_ready to drive when mrc is set
        logic mrc;  // mem_ready matters in this cycle
        logic dec;  // drive the real opcode/func (DECODE cycle)
    } step_t;

    step_t sq[$];
    logic  ill_pending = 1'b0;
    int    last_len, last_irw, last_rw, last_mw, last_ill;

    // Output table of the controller, one phase at a time.
    function automatic exp_t phase(input logic [3:0] st, input logic mr, input logic slti);
        exp_t e = '0;
        e.st = st;
        if (st == S_FETCH) begin
            e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr;
        end else if (st == S_DECODE) begin
            e.asb = 2'b11;
        end else if (st == S_MEMADR) begin
            e.asa = 1; e.asb = 2'b10;
        end else if (st == S_MEMRD) begin
            e.iord = 1; e.mrd = 1;
        end else if (st == S_MEMWB) begin
            e.rw = 1; e.m2r = 2'b01;
        end else if (st == S_MEMWR) begin
            e.iord = 1; e.mwr = 1;
        end else if (st == S_REXEC) begin
            e.asa = 1; e.aop = 2'b10;
        end else if (st == S_RWB) begin
            e.rw = 1; e.rd = 2'b01;
        end else if (st == S_IEXEC) begin
            e.asa = 1; e.asb = 2'b10; e.aop = slti ? 2'b11 : 2'b00;
        end else if (st == S_IWB) begin
            e.rw = 1;
        end else if (st == S_BEQ) begin
            e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01;
        end else if (st == S_JUMP) begin
            e.pcw = 1; e.psrc = 2'b10;
        end else if (st == S_JAL) begin
            e.pcw = 1; e.psrc = 2'b10; e.rw = 1; e.rd = 2'b10; e.m2r = 2'b10;
        end else if (st == S_JR) begin
            e.pcw = 1; e.psrc = 2'b11;
        end
        return e;
    endfunction

    function automatic step_t mk(input logic [3:0] st, input logic mr, input logic mrc,
                                 input logic dec, input logic slti);
        step_t s;
        s.e   = phase(st, mr, slti);
        s.mr  = mr;
        s.mrc = mrc;
        s.dec = dec;
        return s;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0A};
    endfunction

    // FETCH-to-FETCH cycle count from the instruction's documented latency.
    function automatic int spec_lat(input logic [5:0] op, input logic [5:0] fn,
                                    input int wf, input int wm);
        int base;
        case (op)
            6'h23:               base = 5;
            6'h2B, 6'h08, 6'h0A: base = 4;
            6'h00:               base = (fn == 6'h08) ? 3 : 4;
            6'h04, 6'h02, 6'h03: base = 3;
            default:             base = 2;
        endcase
        return base + wf + ((op == 6'h23 || op == 6'h2B) ? wm : 0);
    endfunction

    // Build the expected cycle sequence for one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        sq.delete();
        for (int i = 0; i < wf; i++) sq.push_back(mk(S_FETCH, 1'b0, 1'b1, 1'b0, 1'b0));
        sq.push_back(mk(S_FETCH, 1'b1, 1'b1, 1'b0, 1'b0));
        sq.push_back(mk(S_DECODE, 1'b0, 1'b0, 1'b1, 1'b0));
        if (op == 6'h23) begin
            sq.push_back(mk(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < wm; i++) sq.push_back(mk(S_MEMRD, 1'b0, 1'b1, 1'b0, 1'b0));
            sq.push_back(mk(S_MEMRD, 1'b1, 1'b1, 1'b0, 1'b0));
            sq.push_back(mk(S_MEMWB, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h2B) begin
            sq.push_back(mk(S_MEMADR, 1'b0, 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < wm; i++) sq.push_back(mk(S_MEMWR, 1'b0, 1'b1, 1'b0, 1'b0));
            sq.push_back(mk(S_MEMWR, 1'b1, 1'b1, 1'b0, 1'b0));
        end else if (op == 6'h00 && fn == 6'h08) begin
            sq.push_back(mk(S_JR, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h00) begin
            sq.push_back(mk(S_REXEC, 1'b0, 1'b0, 1'b0, 1'b0));
            sq.push_back(mk(S_RWB, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h04) begin
            sq.push_back(mk(S_BEQ, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h02) begin
            sq.push_back(mk(S_JUMP, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h03) begin
            sq.push_back(mk(S_JAL, 1'b0, 1'b0, 1'b0, 1'b0));
        end else if (op == 6'h08 || op == 6'h0A) begin
            sq.push_back(mk(S_IEXEC, 1'b0, 1'b0, 1'b0, op == 6'h0A));
            sq.push_back(mk(S_IWB, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        if (ill_pending) sq[0].e.ill = 1'b1;
        ill_pending = !is_legal(op);
    endtask

    // Runs one instruction from a negedge in its first FETCH cycle and stops at
    // the negedge of the next instruction's first FETCH cycle (nothing driven yet).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf, input int wm);
        int   k    = 0;
        bit   left = 0;
        exp_t obs;
        build(op, fn, wf, wm);
        last_irw = 0; last_rw = 0; last_mw = 0; last_ill = 0;
        forever begin
            if (left && state_dbg == S_FETCH) break;
            if (k >= 40) begin
                n_checks++; n_fail++;
                $display("FAIL instr_timeout op=%h: still in state %0d after %0d cycles",
                         op, state_dbg, k);
                break;
            end
            if (state_dbg != S_FETCH) left = 1;
            if (k < sq.size()) begin
                mem_ready = sq[k].mrc ? sq[k].mr : 1'($urandom);
                opcode    = sq[k].dec ? op : 6'($urandom);
                func      = sq[k].dec ? fn : 6'($urandom);
            end else begin
                mem_ready = 1'b1;
                opcode    = 6'($urandom);
                func      = 6'($urandom);
            end
            #1;
            obs = '{state_dbg, pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};
            if (k < sq.size()) begin
                n_checks++;
                if (obs !== sq[k].e) begin
                    n_fail++;
                    $display("FAIL cycle op=%h fn=%h step=%0d: got %h expected %h",
                             op, fn, k, obs, sq[k].e);
                end
            end
            last_irw += int'(ir_write);
            last_rw  += int'(reg_write);
            last_mw  += int'(mem_write);
            last_ill += int'(illegal);
            k++;
            @(negedge clk);
        end
        last_len = k;
        n_checks++;
        if (last_len != sq.size()) begin
            n_fail++;
            $display("FAIL model_len op=%h: got %0d cycles, model %0d", op, last_len, sq.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b1; opcode = 6'h23; func = 6'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode = 6'($urandom);
            #1;
            n_checks++;
            if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal,
                 reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got nonzero enables/selects", i);
            end
            n_checks++;
            if (state_dbg !== S_FETCH) begin
                n_fail++;
                $display("FAIL reset_state cycle %0d: got %0d required %0d", i, state_dbg, S_FETCH);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== S_FETCH || mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: state %0d mem_read %b, required %0d and 1",
                     state_dbg, mem_read, S_FETCH);
        end
    endtask

    task automatic test_lw();
        run_instr(6'h23, 6'($urandom), 0, 0);
        n_checks++;
        if (last_len != 5 || last_rw != 1) begin
            n_fail++;
            $display("FAIL lw: len %0d reg_write %0d, required 5 and 1", last_len, last_rw);
        end
    endtask

    task automatic test_mem_wait();
        run_instr(6'h23, 6'h00, 2, 3);
        n_checks++;
        if (last_len != 10 || last_irw != 1 || last_rw != 1) begin
            n_fail++;
            $display("FAIL mem_wait: len %0d ir_write %0d reg_write %0d, required 10 1 1",
                     last_len, last_irw, last_rw);
        end
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h20, 0, 0);
        n_checks++;
        if (last_len != 4 || last_rw != 1) begin
            n_fail++;
            $display("FAIL rtype: len %0d reg_write %0d, required 4 and 1", last_len, last_rw);
        end
    endtask

    task automatic test_jr();
        run_instr(6'h00, 6'h08, 0, 0);
        n_checks++;
        if (last_len != 3 || last_rw != 0) begin
            n_fail++;
            $display("FAIL jr: len %0d reg_write %0d, required 3 and 0", last_len, last_rw);
        end
    endtask

    task automatic test_jal();
        run_instr(6'h03, 6'h00, 0, 0);
        n_checks++;
        if (last_len != 3 || last_rw != 1) begin
            n_fail++;
            $display("FAIL jal: len %0d reg_write %0d, required 3 and 1", last_len, last_rw);
        end
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h00, 0, 0);
        n_checks++;
        if (last_len != 2 || last_rw != 0 || last_mw != 0) begin
            n_fail++;
            $display("FAIL illegal_seq: len %0d reg_write %0d mem_write %0d, required 2 0 0",
                     last_len, last_rw, last_mw);
        end
        run_instr(6'h0A, 6'h00, 1, 0);
        n_checks++;
        if (last_ill != 1 || last_len != 5) begin
            n_fail++;
            $display("FAIL illegal_pulse: pulses %0d len %0d, required 1 and 5", last_ill, last_len);
        end
    endtask

    task automatic test_reset_midflight();
        mem_ready = 1'b1; opcode = 6'($urandom);
        @(negedge clk);
        opcode = 6'h2B;
        @(negedge clk);
        opcode = 6'($urandom);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== S_MEMWR || mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_memwr: state %0d mem_write %b, required %0d and 1",
                     state_dbg, mem_write, S_MEMWR);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_write, reg_write, pc_write, pc_write_cond, ir_write, mem_read} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_abort: mem_write %b reg_write %b pc_write %b, required 0",
                     mem_write, reg_write, pc_write);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if (state_dbg !== S_FETCH) begin
            n_fail++;
            $display("FAIL reset_abort_fetch: state %0d required %0d", state_dbg, S_FETCH);
        end
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        int         sel, wf, wm;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 10);
            fn  = 6'($urandom);
            case (sel)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: begin op = 6'h00; if (fn == 6'h08) fn = 6'h20; end
                3: begin op = 6'h00; fn = 6'h08; end
                4: op = 6'h04;
                5: op = 6'h02;
                6: op = 6'h03;
                7: op = 6'h08;
                8: op = 6'h0A;
                default: begin
                    do op = 6'($urandom); while (is_legal(op));
                end
            endcase
            wf = $urandom_range(0, 2);
            wm = $urandom_range(0, 2);
            run_instr(op, fn, wf, wm);
            n_checks++;
            if (last_len != spec_lat(op, fn, wf, wm) || last_irw != 1) begin
                n_fail++;
                $display("FAIL random_lat op=%h fn=%h: len %0d ir_write %0d, required %0d and 1",
                         op, fn, last_len, last_irw, spec_lat(op, fn, wf, wm));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_mem_wait();
        test_rtype();
        test_jr();
        test_jal();
        test_illegal();
        test_reset_midflight();
        ill_pending = 1'b0;
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
